// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: control-bit positions and default widths/masks
// so every pipeline register in the core agrees on where each control bit lives.
package pipe_pkg;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_JUMP     = 5;
  localparam int CTRL_RET      = 6;

  localparam int CTRL_W_DEF = 7;
  localparam int DATA_W_DEF = 81;

  // A hazard kill squashes only the return bit by default.
  localparam logic [CTRL_W_DEF-1:0] KILL_MASK_DEF = 7'(1 << CTRL_RET);

endpackage

// File: rtl/pipe_stage.sv
// One pipeline-register stage: valid/ctrl/payload registers plus its advance/ready logic.
// Control bits are cleared whenever the stage goes empty; payload is never reset.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  input  logic              down_ready,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data,
  output logic              advance,
  output logic              ready
);

  logic              valid_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] data_r;
  logic              advance_s;

  assign advance_s = valid_r & down_ready;
  assign advance   = advance_s;
  assign ready     = ~valid_r | advance_s;
  assign valid     = valid_r;
  assign ctrl      = ctrl_r;
  assign data      = data_r;

  // Valid and control state: reset, flush, load, drain-to-empty or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
    end else if (flush) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      ctrl_r  <= load_ctrl;
    end else if (advance_s) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
    end else begin
      valid_r <= valid_r;
      ctrl_r  <= ctrl_r;
    end
  end

  // Payload captures on load only; it simply holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst && !flush && load) begin
      data_r <= load_data;
    end else begin
      data_r <= data_r;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of STAGES pipeline registers with valid/ready handshake, bubble collapsing,
// whole-chain flush, hazard-kill mask on entry and an occupancy counter.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int                STAGES    = 2,
  parameter int                CTRL_W    = CTRL_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [CTRL_W-1:0] KILL_MASK = KILL_MASK_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        clr_hazard,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CTRL_W-1:0]           in_ctrl,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CTRL_W-1:0]           out_ctrl,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(STAGES+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(STAGES + 1);

  logic              accept_s;
  logic              deq_s;
  logic [CTRL_W-1:0] kill_s;
  logic [OCC_W-1:0]  occ_r;

  // Mask applied to the entering control word.
  always_comb begin
    kill_s = {CTRL_W{1'b0}};
    if (clr_hazard) begin
      kill_s = KILL_MASK;
    end else begin
      kill_s = {CTRL_W{1'b0}};
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              valid_s;
    logic              ready_s;
    logic              advance_s;
    logic              load_s;
    logic              down_ready_s;
    logic [CTRL_W-1:0] ctrl_s;
    logic [CTRL_W-1:0] load_ctrl_s;
    logic [DATA_W-1:0] data_s;
    logic [DATA_W-1:0] load_data_s;

    if (k == 0) begin : g_head
      assign load_s      = accept_s;
      assign load_ctrl_s = in_ctrl & ~kill_s;
      assign load_data_s = in_data;
    end else begin : g_body
      assign load_s      = g_stage[k-1].advance_s;
      assign load_ctrl_s = g_stage[k-1].ctrl_s;
      assign load_data_s = g_stage[k-1].data_s;
    end

    // Ready ripples back from the output, so an empty stage fills even under stall.
    if (k == STAGES - 1) begin : g_tail
      assign down_ready_s = out_ready;
    end else begin : g_mid
      assign down_ready_s = g_stage[k+1].ready_s;
    end

    pipe_stage #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .load       (load_s),
      .load_ctrl  (load_ctrl_s),
      .load_data  (load_data_s),
      .down_ready (down_ready_s),
      .valid      (valid_s),
      .ctrl       (ctrl_s),
      .data       (data_s),
      .advance    (advance_s),
      .ready      (ready_s)
    );
  end

  assign in_ready  = g_stage[0].ready_s;
  assign accept_s  = in_valid & g_stage[0].ready_s & ~flush;
  assign deq_s     = g_stage[STAGES-1].advance_s;
  assign out_valid = g_stage[STAGES-1].valid_s;
  assign out_ctrl  = g_stage[STAGES-1].ctrl_s;
  assign out_data  = g_stage[STAGES-1].data_s;
  assign occupancy = occ_r;

  // Occupancy tracks accepts and consumptions; flush empties the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (flush) begin
      occ_r <= {OCC_W{1'b0}};
    end else begin
      case ({accept_s, deq_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain with STAGES=2 defaults.
module tb_pipe_stage_chain;

  logic        clk = 1'b0;
  logic        rst, flush, clr_hazard, in_valid, in_ready, out_valid, out_ready;
  logic [6:0]  in_ctrl, out_ctrl;
  logic [80:0] in_data, out_data;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  pipe_stage_chain dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .clr_hazard (clr_hazard),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic v, input logic [6:0] c, input logic [80:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; clr_hazard = 1'b0; out_ready = 1'b1;
    put(1'b1, 7'h7F, 81'd99);

    // 1 reset
    tick();
    tick();
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_out_ctrl",  128'(out_ctrl),  128'(7'h00));
    check("rst_occ",       128'(occupancy), 128'(2'd0));
    check("rst_in_ready",  128'(in_ready),  128'(1'b1));
    put(1'b0, 7'h00, 81'd0);
    rst = 1'b0;
    tick();

    // 2 streaming 1..8
    for (int i = 1; i <= 10; i++) begin
      if (i <= 8) put(1'b1, 7'(i), 81'(i));
      else        put(1'b0, 7'h00, 81'd0);
      tick();
      check("stream_valid", 128'(out_valid), 128'((i >= 2 && i <= 9) ? 1 : 0));
      check("stream_occ", 128'(occupancy),
            128'((i == 1) ? 1 : (i <= 8) ? 2 : (i == 9) ? 1 : 0));
      if (i >= 2 && i <= 9) begin
        check("stream_data", 128'(out_data), 128'(i - 1));
        check("stream_ctrl", 128'(out_ctrl), 128'(i - 1));
      end
    end

    // 3 back-pressure
    out_ready = 1'b0;
    put(1'b1, 7'h01, 81'hA1); tick();
    put(1'b1, 7'h02, 81'hA2); tick();
    put(1'b1, 7'h03, 81'hA3);
    #1;
    check("bp_in_ready", 128'(in_ready), 128'(1'b0));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_occ",   128'(occupancy), 128'(2'd2));
      check("bp_valid", 128'(out_valid), 128'(1'b1));
      check("bp_data",  128'(out_data),  128'(81'hA1));
      check("bp_ready", 128'(in_ready),  128'(1'b0));
    end
    put(1'b0, 7'h00, 81'd0);
    out_ready = 1'b1;
    tick();
    check("bp_drain1_data", 128'(out_data),  128'(81'hA2));
    check("bp_drain1_ctrl", 128'(out_ctrl),  128'(7'h02));
    check("bp_drain1_occ",  128'(occupancy), 128'(2'd1));
    tick();
    check("bp_drain2_valid", 128'(out_valid), 128'(1'b0));
    check("bp_drain2_occ",   128'(occupancy), 128'(2'd0));

    // 4 flush
    out_ready = 1'b0;
    put(1'b1, 7'h11, 81'hB1); tick();
    put(1'b1, 7'h12, 81'hB2); tick();
    check("fl_pre_occ", 128'(occupancy), 128'(2'd2));
    flush = 1'b1;
    clr_hazard = 1'b1;
    put(1'b1, 7'h55, 81'hB3);
    #1;
    check("fl_cycle_valid", 128'(out_valid), 128'(1'b1));
    check("fl_cycle_ctrl",  128'(out_ctrl),  128'(7'h11));
    tick();
    flush = 1'b0;
    clr_hazard = 1'b0;
    put(1'b0, 7'h00, 81'd0);
    check("fl_occ",   128'(occupancy), 128'(2'd0));
    check("fl_valid", 128'(out_valid), 128'(1'b0));
    check("fl_ctrl",  128'(out_ctrl),  128'(7'h00));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_leak", 128'(out_valid), 128'(1'b0));
    end

    // 5 hazard kill
    clr_hazard = 1'b1;
    put(1'b1, 7'h7F, 81'hC1); tick();
    clr_hazard = 1'b0;
    put(1'b1, 7'h7F, 81'hC2); tick();
    check("hz_kill_ctrl", 128'(out_ctrl), 128'(7'h3F));
    check("hz_kill_data", 128'(out_data), 128'(81'hC1));
    put(1'b0, 7'h00, 81'd0); tick();
    check("hz_keep_ctrl", 128'(out_ctrl), 128'(7'h7F));
    check("hz_keep_data", 128'(out_data), 128'(81'hC2));
    tick();
    check("hz_empty_ctrl", 128'(out_ctrl), 128'(7'h00));

    // 6 bubble collapse
    out_ready = 1'b0;
    put(1'b1, 7'h02, 81'hD1); tick();
    put(1'b0, 7'h00, 81'd0);  tick();
    check("bub_occ1", 128'(occupancy), 128'(2'd1));
    check("bub_out1", 128'(out_data),  128'(81'hD1));
    put(1'b1, 7'h03, 81'hD2); tick();
    put(1'b0, 7'h00, 81'd0);
    check("bub_occ2",  128'(occupancy), 128'(2'd2));
    check("bub_head",  128'(out_data),  128'(81'hD1));
    check("bub_ready", 128'(in_ready),  128'(1'b0));
    out_ready = 1'b1;
    tick();
    check("bub_next_data", 128'(out_data),  128'(81'hD2));
    check("bub_next_ctrl", 128'(out_ctrl),  128'(7'h03));
    check("bub_next_occ",  128'(occupancy), 128'(2'd1));
    tick();
    check("bub_end_occ", 128'(occupancy), 128'(2'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
